receiver_ack_scheduler: RTL and testbench



---
 rtl/receiver_ack_scheduler_pkg.sv | 28 ++
 rtl/ack_timeout_timer.sv | 33 +++
 rtl/receiver_ack_scheduler.sv | 142 ++++++++++++++
 tb/tb_receiver_ack_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/receiver_ack_scheduler_pkg.sv
// Shared types and constants for the receive-path ACK/NAK scheduler.
// CONFIG_TLP_ID_WIDTH sets the default sequence ID width; RX_ACK_COALESCE_EN is consumed by the top.
`ifndef CONFIG_TLP_ID_WIDTH
`define CONFIG_TLP_ID_WIDTH 8
`endif

package receiver_ack_scheduler_pkg;

  localparam int DEF_TLP_ID_WIDTH     = `CONFIG_TLP_ID_WIDTH;
  localparam int DEF_ACK_COALESCE_MAX = 4;
  localparam int DEF_ACK_TIMEOUT      = 64;

  // DLLP type encodings carried on o_dllp_nak
  localparam logic RX_DLLP_ACK = 1'b0;
  localparam logic RX_DLLP_NAK = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ISSUE   = 2'd2
  } state_t;

  // The NAK flag sits just above the sequence ID in a status entry.
  function automatic int status_nak_bit(input int id_width);
    return id_width;
  endfunction

endpackage

// File: rtl/ack_timeout_timer.sv
// Clearable, enabled up-counter that flags the last cycle a pending ACK may wait.
// Only compiled when RX_ACK_COALESCE_EN is defined.
`ifdef RX_ACK_COALESCE_EN
module ack_timeout_timer #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_arst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = $clog2(ACK_TIMEOUT);
  localparam logic [W-1:0] LAST = W'(ACK_TIMEOUT - 1);

  logic [W-1:0] count;

  assign o_expire = i_en & (count == LAST);

  // Saturates at LAST so the counter never wraps while the FSM leaves COLLECT.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      count <= '0;
    end else if (i_clr) begin
      count <= '0;
    end else if (i_en && !o_expire) begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/receiver_ack_scheduler.sv
// Pops receiver status entries, coalesces good IDs into one ACK and issues NAKs first.
// RX_ACK_COALESCE_EN enables coalescing/timeout; without it every good status is ACKed alone.
module receiver_ack_scheduler
  import receiver_ack_scheduler_pkg::*;
#(
  parameter int TLP_ID_WIDTH     = DEF_TLP_ID_WIDTH,
  parameter int ACK_COALESCE_MAX = DEF_ACK_COALESCE_MAX,
  parameter int ACK_TIMEOUT      = DEF_ACK_TIMEOUT
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic [TLP_ID_WIDTH:0]   i_status_id,
  input  logic                    i_status_id_valid,
  output logic                    o_status_id_rd,
  output logic                    o_dllp_req,
  output logic                    o_dllp_nak,
  output logic [TLP_ID_WIDTH-1:0] o_dllp_id,
  input  logic                    i_dllp_ack,
  output logic                    o_pending,
  output state_t                  o_dbg_state
);

`ifdef RX_ACK_COALESCE_EN
  localparam int EFF_MAX = ACK_COALESCE_MAX;
`else
  localparam int EFF_MAX = 1;
`endif
  localparam int CNT_W   = $clog2(EFF_MAX + 1);
  localparam int NAK_BIT = status_nak_bit(TLP_ID_WIDTH);

  if (ACK_COALESCE_MAX < 1 || ACK_TIMEOUT < 2) begin : g_cfg_check
    $error("receiver_ack_scheduler: ACK_COALESCE_MAX must be >= 1 and ACK_TIMEOUT >= 2");
  end

  state_t                  state, next_state;
  logic [CNT_W-1:0]        pend_cnt;
  logic [TLP_ID_WIDTH-1:0] last_id, issue_id, load_id, st_id;
  logic                    issue_nak, load_nak, load, st_nak;
  logic                    pop, hit_max, timer_expire;

  assign st_id   = i_status_id[TLP_ID_WIDTH-1:0];
  assign st_nak  = i_status_id[NAK_BIT];
  assign hit_max = ((int'(pend_cnt) + 1) == EFF_MAX);

  // Status port is a pop interface: an entry is consumed in any cycle where
  // i_status_id_valid and o_status_id_rd are both high. The DLLP port is a
  // request/acknowledge pair: o_dllp_req and its fields hold until i_dllp_ack
  // is sampled high, and i_dllp_ack is ignored while no request is up.
  assign pop = i_status_id_valid & ~i_arst &
               ((state == ST_IDLE) | ((state == ST_COLLECT) & ~timer_expire));

`ifdef RX_ACK_COALESCE_EN
  ack_timeout_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .i_clk    (i_clk),
    .i_arst   (i_arst),
    .i_clr    (next_state != ST_COLLECT),
    .i_en     (state == ST_COLLECT),
    .o_expire (timer_expire)
  );
`else
  assign timer_expire = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_nak   = RX_DLLP_ACK;
    load_id    = last_id;
    case (state)
      ST_IDLE, ST_COLLECT: begin
        if (timer_expire) begin
          next_state = ST_ISSUE;
          load       = 1'b1;
        end else if (pop) begin
          load_id = st_id;
          // A NAK ID implicitly acknowledges everything before it, so any pending ACK is dropped.
          if (st_nak) begin
            next_state = ST_ISSUE;
            load       = 1'b1;
            load_nak   = RX_DLLP_NAK;
          end else if (hit_max) begin
            next_state = ST_ISSUE;
            load       = 1'b1;
          end else begin
            next_state = ST_COLLECT;
          end
        end
      end
      ST_ISSUE: begin
        if (i_dllp_ack) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      pend_cnt  <= '0;
      last_id   <= '0;
      issue_nak <= RX_DLLP_ACK;
      issue_id  <= '0;
    end else begin
      if (load) begin
        issue_nak <= load_nak;
        issue_id  <= load_id;
        pend_cnt  <= '0;
      end else if (pop) begin
        pend_cnt <= pend_cnt + 1'b1;
      end
      if (pop && !st_nak) begin
        last_id <= st_id;
      end
    end
  end

  always_comb begin
    o_dllp_req     = (state == ST_ISSUE);
    o_dllp_nak     = issue_nak;
    o_dllp_id      = issue_id;
    o_status_id_rd = pop;
    o_dbg_state    = state;
  end

`ifdef RX_ACK_COALESCE_EN
  assign o_pending = (pend_cnt != '0);
`else
  assign o_pending = 1'b0;
`endif

endmodule

// File: tb/tb_receiver_ack_scheduler.sv
// Directed bench for receiver_ack_scheduler: vector table plus multi-cycle corner sequences.
// Follows RX_ACK_COALESCE_EN to select the coalescing or one-ACK-per-status expectations.
module tb_receiver_ack_scheduler;
  import receiver_ack_scheduler_pkg::*;

  localparam int W  = 8;
  localparam int TO = 16;
`ifdef RX_ACK_COALESCE_EN
  localparam int EMAX = 4;
`else
  localparam int EMAX = 1;
`endif

  typedef struct {
    logic         valid;
    logic [W:0]   status;
    logic         ack;
    logic         rd;
    logic         req;
    logic         nak;
    logic [W-1:0] id;
    logic         pend;
  } vec_t;

  logic         clk = 1'b0;
  logic         arst;
  logic [W:0]   status;
  logic         valid, ack;
  logic         rd, req, nak, pending;
  logic [W-1:0] id;
  state_t       dbg;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [W:0] exp_q[$];
  vec_t tbl[$];

  receiver_ack_scheduler #(
    .TLP_ID_WIDTH     (W),
    .ACK_COALESCE_MAX (4),
    .ACK_TIMEOUT      (TO)
  ) dut (
    .i_clk             (clk),
    .i_arst            (arst),
    .i_status_id       (status),
    .i_status_id_valid (valid),
    .o_status_id_rd    (rd),
    .o_dllp_req        (req),
    .o_dllp_nak        (nak),
    .o_dllp_id         (id),
    .i_dllp_ack        (ack),
    .o_pending         (pending),
    .o_dbg_state       (dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W:0] s, input logic a);
    valid  = v;
    status = s;
    ack    = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [W:0] s, input logic a, input logic e_rd,
                              input logic e_req, input logic e_nak, input logic [W-1:0] e_id,
                              input logic e_pend);
    vec_t t;
    t.valid = v; t.status = s; t.ack = a;
    t.rd = e_rd; t.req = e_req; t.nak = e_nak; t.id = e_id; t.pend = e_pend;
    return t;
  endfunction

  // scoreboard: every rising request must match the next expected {nak, id}
  logic       req_d = 1'b0;
  logic [W:0] exp_e;
  always @(negedge clk) begin
    if (req && !req_d) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL issue: unexpected req nak=%0b id=%0h", nak, id);
      end else begin
        exp_e = exp_q.pop_front();
        if ({nak, id} !== exp_e) begin
          n_err++;
          $display("FAIL issue: got nak/id %0h expected %0h", {nak, id}, exp_e);
        end
      end
    end
    req_d <= req;
  end

  initial begin
    logic         prev_req;
    logic         seen;
    int           t0, t_req;
    logic [W-1:0] tid;

    drive(1'b0, '0, 1'b0);
    arst = 1'b1;
    #1;
    check("reset req", req, 0);
    check("reset nak", nak, 0);
    check("reset id", id, 0);
    check("reset pending", pending, 0);
    check("reset state", dbg, ST_IDLE);
    @(negedge clk);
    arst = 1'b0;
    step();

`ifdef RX_ACK_COALESCE_EN
    tbl.push_back(mk(1, 9'h000, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 9'h001, 0, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mk(1, 9'h002, 0, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mk(1, 9'h003, 0, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 9'h000, 0, 0, 1, 0, 8'h03, 0));
    tbl.push_back(mk(0, 9'h000, 1, 0, 1, 0, 8'h03, 0));
    tbl.push_back(mk(0, 9'h000, 0, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 9'h001, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 9'h002, 0, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mk(1, 9'h102, 0, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mk(0, 9'h000, 0, 0, 1, 1, 8'h02, 0));
    tbl.push_back(mk(0, 9'h000, 1, 0, 1, 1, 8'h02, 0));
    tbl.push_back(mk(0, 9'h000, 1, 0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 9'h010, 1, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 9'h111, 0, 1, 0, 0, 8'h00, 1));
    tbl.push_back(mk(1, 9'h113, 0, 0, 1, 1, 8'h11, 0));
    tbl.push_back(mk(1, 9'h113, 1, 0, 1, 1, 8'h11, 0));
    tbl.push_back(mk(1, 9'h113, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 9'h000, 0, 0, 1, 1, 8'h13, 0));
    tbl.push_back(mk(0, 9'h000, 1, 0, 1, 1, 8'h13, 0));
    tbl.push_back(mk(0, 9'h000, 0, 0, 0, 0, 8'h00, 0));
`else
    tbl.push_back(mk(1, 9'h000, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 9'h000, 1, 0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(1, 9'h001, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 9'h000, 1, 0, 1, 0, 8'h01, 0));
    tbl.push_back(mk(1, 9'h002, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 9'h000, 1, 0, 1, 0, 8'h02, 0));
    tbl.push_back(mk(1, 9'h105, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 9'h000, 1, 0, 1, 1, 8'h05, 0));
    tbl.push_back(mk(1, 9'h009, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 9'h00a, 0, 0, 1, 0, 8'h09, 0));
    tbl.push_back(mk(1, 9'h00a, 1, 0, 1, 0, 8'h09, 0));
    tbl.push_back(mk(1, 9'h00a, 0, 1, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 9'h000, 1, 0, 1, 0, 8'h0a, 0));
    tbl.push_back(mk(0, 9'h000, 0, 0, 0, 0, 8'h00, 0));
`endif

    prev_req = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].valid, tbl[i].status, tbl[i].ack);
      if (tbl[i].req && !prev_req) exp_q.push_back({tbl[i].nak, tbl[i].id});
      prev_req = tbl[i].req;
      @(negedge clk);
      check($sformatf("v%0d rd", i), rd, tbl[i].rd);
      check($sformatf("v%0d req", i), req, tbl[i].req);
      if (tbl[i].req) begin
        check($sformatf("v%0d nak", i), nak, tbl[i].nak);
        check($sformatf("v%0d id", i), id, tbl[i].id);
      end
      check($sformatf("v%0d pending", i), pending, tbl[i].pend);
      step();
    end

`ifdef RX_ACK_COALESCE_EN
    // timeout: goods 5,6 then silence
    drive(1'b1, 9'h005, 1'b0);
    @(negedge clk);
    check("to pop5", rd, 1);
    t0 = cyc;
    step();
    drive(1'b1, 9'h006, 1'b0);
    @(negedge clk);
    check("to pop6", rd, 1);
    check("to pending", pending, 1);
    step();
    drive(1'b0, '0, 1'b0);
    exp_q.push_back({RX_DLLP_ACK, 8'h06});
    seen  = 1'b0;
    t_req = 0;
    for (int k = 0; k < 2 * TO && !seen; k++) begin
      @(negedge clk);
      if (req) begin
        seen  = 1'b1;
        t_req = cyc;
      end else begin
        step();
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL to wait: got no req expected req within %0d cycles", 2 * TO);
    end else begin
      check("to latency", t_req - t0, TO + 1);
      check("to id", id, 8'h06);
      check("to pending clr", pending, 0);
      step();
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      check("to req held", req, 1);
      step();
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      check("to req drop", req, 0);
      step();
    end

    // valid entry on the expire cycle with a slow transmitter
    drive(1'b1, 9'h020, 1'b0);
    @(negedge clk);
    check("ex pop20", rd, 1);
    step();
    drive(1'b0, '0, 1'b0);
    repeat (TO - 1) step();
    drive(1'b1, 9'h021, 1'b0);
    exp_q.push_back({RX_DLLP_ACK, 8'h20});
    @(negedge clk);
    check("ex no pop on expire", rd, 0);
    check("ex req low", req, 0);
    step();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("ex hold%0d req", k), req, 1);
      check($sformatf("ex hold%0d rd", k), rd, 0);
      check($sformatf("ex hold%0d id", k), {nak, id}, {RX_DLLP_ACK, 8'h20});
      step();
    end
    drive(1'b1, 9'h021, 1'b1);
    @(negedge clk);
    check("ex ack req", req, 1);
    check("ex ack rd", rd, 0);
    step();
    drive(1'b1, 9'h021, 1'b0);
    @(negedge clk);
    check("ex req drop", req, 0);
    check("ex pop21", rd, 1);
    step();
    drive(1'b1, 9'h122, 1'b0);
    exp_q.push_back({RX_DLLP_NAK, 8'h22});
    @(negedge clk);
    check("ex pending", pending, 1);
    check("ex pop nak", rd, 1);
    step();
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    check("ex nak req", req, 1);
    step();
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check("ex nak done", req, 0);
    check("ex nak pending", pending, 0);
    step();
`endif

    // reset pulsed while a request is up
    for (int k = 0; k < EMAX; k++) begin
      tid = 8'h40 + 8'(k);
      drive(1'b1, {1'b0, tid}, 1'b0);
      @(negedge clk);
      check($sformatf("rs pop%0d", k), rd, 1);
      step();
    end
    tid = 8'h40 + 8'(EMAX - 1);
    exp_q.push_back({RX_DLLP_ACK, tid});
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check("rs req up", req, 1);
    #1;
    arst = 1'b1;
    #1;
    check("rs req async", req, 0);
    check("rs pending", pending, 0);
    check("rs state", dbg, ST_IDLE);
    drive(1'b1, 9'h050, 1'b0);
    #1;
    check("rs no pop", rd, 0);
    drive(1'b0, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    step();
    for (int k = 0; k < EMAX; k++) begin
      tid = 8'h60 + 8'(k);
      drive(1'b1, {1'b0, tid}, 1'b0);
      @(negedge clk);
      check($sformatf("rs2 pop%0d", k), rd, 1);
      check($sformatf("rs2 pend%0d", k), pending, (k > 0) ? 1 : 0);
      step();
    end
    tid = 8'h60 + 8'(EMAX - 1);
    exp_q.push_back({RX_DLLP_ACK, tid});
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    check("rs2 req", req, 1);
    check("rs2 id", id, tid);
    step();
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check("rs2 done", req, 0);
    check("rs2 pending", pending, 0);
    step();

    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
